src_register_file: RTL and testbench
====================================

Name: src_register_file

Overview:
- Parametrised successor to the single 32-bit enable register: a bank of DEPTH general-purpose registers for the Mini SRC datapath.
- Provides one write port and two combinational read ports (A and B), with write-through bypass.
- Implements SRC R0 base-address semantics: R0 reads as zero on port A when ba_out is asserted.
- Keeps a per-register pending-write scoreboard so control logic can detect read-after-write hazards.

Parameters:
- WIDTH, 32, data width of each register.
- DEPTH, 16, number of registers; must be a power of two, at least 2.
- ADDR_W, 4, address width; must equal log2(DEPTH).

Ports:
- clock  input  1  rising-edge clock.
- clear  input  1  asynchronous active-low reset: registers and scoreboard clear on negedge clear and stay cleared while clear is 0.
- wr_en  input  1  write enable for the write port.
- wr_addr  input  ADDR_W  write register index.
- wr_data  input  WIDTH  write data.
- rd_addr_a  input  ADDR_W  read port A index.
- rd_data_a  output  WIDTH  read port A data.
- rd_addr_b  input  ADDR_W  read port B index.
- rd_data_b  output  WIDTH  read port B data.
- ba_out  input  1  base-address mode; forces rd_data_a to zero when rd_addr_a is 0.
- rsv_en  input  1  reserve: mark a register as pending write.
- rsv_addr  input  ADDR_W  register index to reserve.
- busy_a  output  1  the register at rd_addr_a is pending.
- busy_b  output  1  the register at rd_addr_b is pending.
- any_busy  output  1  at least one register is pending.

Behaviour:
- Reset (clear=0):
  - All DEPTH registers become 0; all pending bits become 0.
  - Reads return 0; busy_a, busy_b and any_busy are 0.
  - Writes and reserves are ignored until clear returns to 1; the first sampling edge is the first posedge with clear=1.
- Write:
  - With wr_en=1 at a posedge, reg[wr_addr] takes wr_data. The register array output reflects it one cycle later.
  - R0 is a normal writable register. Only ba_out masks it, and only on port A.
- Read: combinational from rd_addr_x, zero-cycle latency.
- Bypass:
  - If wr_en=1 and wr_addr equals rd_addr_x, rd_data_x returns wr_data in the same cycle, before the edge. This applies to each port independently.
- Base-address masking:
  - If ba_out=1 and rd_addr_a=0, rd_data_a=0. This takes priority over bypass.
  - Port B is never masked.
- Scoreboard:
  - pending[rsv_addr] is set at a posedge when rsv_en=1.
  - pending[wr_addr] is cleared at a posedge when wr_en=1.
  - Same address, same edge, with both rsv_en=1 and wr_en=1: the data is written and pending ends set, because a new producer was issued.
  - Different addresses on the same edge: both actions take effect.
  - busy_x = pending[rd_addr_x], taken from registered state (no bypass).
  - any_busy = OR of all pending bits.
- Writing a register that is not pending is legal; its pending bit stays 0.
- Reset asserted mid-operation: takes effect immediately and asynchronously; any same-cycle write or reserve is lost.
- Addresses are always in range, because DEPTH = 2^ADDR_W; no wrap logic is needed.

Test Plan:
- Reset, then write: hold clear=0, then release; write R5=0xDEADBEEF; next cycle read A=5, B=5 -> both 0xDEADBEEF; all other registers read 0.
- Bypass: R3=0x11111111; same cycle wr_en=1, wr_addr=3, wr_data=0x22222222, rd_addr_a=3 -> rd_data_a=0x22222222 before the edge; after the edge both ports read 0x22222222.
- Base-address masking: R0=0x00000040; ba_out=1, rd_addr_a=0, rd_addr_b=0 -> rd_data_a=0, rd_data_b=0x00000040; ba_out=0 -> rd_data_a=0x00000040; repeat with a same-cycle write to R0 -> port A still 0.
- Scoreboard: rsv_en on R7 -> next cycle busy_a=1 (rd_addr_a=7), any_busy=1. Write R7 -> next cycle busy_a=0, any_busy=0. Reserve and write R7 on the same edge -> busy_a=1 afterwards, R7 holds the new data.
- Async reset mid-operation: with R9=0x12345678 and R2 pending, drop clear between edges -> rd_data for R9 is 0 and any_busy is 0 immediately, without waiting for a clock edge. Writes presented while clear=0 are ignored.
- Width parameter: instantiate WIDTH=8, DEPTH=4, ADDR_W=2; write R3=0xA5; read B=3 -> 0xA5; R0 masking and scoreboard behave the same as in the 32-bit configuration.

Source files
------------

// File: rtl/src_register_file_if.sv
// src_register_file_if
//   Bus bundle for the Mini SRC general-purpose register file.
//   master : datapath/control side (drives write, read, reserve requests)
//   slave  : register file side (returns read data and hazard flags)
//   Signals: wr_en/wr_addr/wr_data (write port), rd_addr_a/rd_data_a and
//   rd_addr_b/rd_data_b (read ports), ba_out (R0 base-address mode),
//   rsv_en/rsv_addr (reserve), busy_a/busy_b/any_busy (pending flags).
interface src_register_file_if #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 4
);
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [ADDR_W-1:0] rd_addr_a;
  logic [WIDTH-1:0]  rd_data_a;
  logic [ADDR_W-1:0] rd_addr_b;
  logic [WIDTH-1:0]  rd_data_b;
  logic              ba_out;
  logic              rsv_en;
  logic [ADDR_W-1:0] rsv_addr;
  logic              busy_a;
  logic              busy_b;
  logic              any_busy;

  modport master (
    output wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, ba_out,
           rsv_en, rsv_addr,
    input  rd_data_a, rd_data_b, busy_a, busy_b, any_busy
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, rd_addr_a, rd_addr_b, ba_out,
           rsv_en, rsv_addr,
    output rd_data_a, rd_data_b, busy_a, busy_b, any_busy
  );
endinterface

// File: rtl/src_register_file.sv
// src_register_file
//   DEPTH x WIDTH register bank for the Mini SRC datapath: one write port,
//   two combinational read ports with write-through bypass, R0 masking on
//   port A in base-address mode, and a per-register pending-write
//   scoreboard for read-after-write hazard detection.
//   Ports:
//     clock : rising-edge clock
//     clear : asynchronous active-low reset (registers and pending bits)
//     bus   : src_register_file_if.slave (see interface for signal list)
//   DEPTH must be 2**ADDR_W; interface WIDTH/ADDR_W must match.
module src_register_file #(
  parameter int WIDTH  = 32,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic                clock,
  input  logic                clear,
  src_register_file_if.slave  bus
);

  logic [WIDTH-1:0] regs [DEPTH];
  logic [DEPTH-1:0] pending;
  logic [DEPTH-1:0] pending_nxt;

  // Reserve is applied after the write-clear so a same-address reserve and
  // write leaves the register pending: a new producer has been issued.
  always_comb begin
    pending_nxt = pending;
    if (bus.wr_en)  pending_nxt[bus.wr_addr]  = 1'b0;
    if (bus.rsv_en) pending_nxt[bus.rsv_addr] = 1'b1;
  end

  always_ff @(posedge clock or negedge clear) begin
    if (!clear) begin
      for (int i = 0; i < DEPTH; i++) regs[i] <= '0;
      pending <= '0;
    end else begin
      if (bus.wr_en) regs[bus.wr_addr] <= bus.wr_data;
      pending <= pending_nxt;
    end
  end

  // Bypass is gated by clear so reads stay zero throughout reset even if a
  // write is being presented.
  always_comb begin
    bus.rd_data_a = regs[bus.rd_addr_a];
    if (bus.ba_out && (bus.rd_addr_a == '0))
      bus.rd_data_a = '0;
    else if (clear && bus.wr_en && (bus.wr_addr == bus.rd_addr_a))
      bus.rd_data_a = bus.wr_data;
  end

  always_comb begin
    bus.rd_data_b = regs[bus.rd_addr_b];
    if (clear && bus.wr_en && (bus.wr_addr == bus.rd_addr_b))
      bus.rd_data_b = bus.wr_data;
  end

  // Hazard flags come from registered state only; no bypass.
  assign bus.busy_a   = pending[bus.rd_addr_a];
  assign bus.busy_b   = pending[bus.rd_addr_b];
  assign bus.any_busy = |pending;

endmodule

// File: tb/tb_src_register_file.sv
module tb_src_register_file;
  logic clock = 1'b0;
  logic clear = 1'b0;
  always #5 clock = ~clock;

  src_register_file_if #(.WIDTH(32), .ADDR_W(4)) b();
  src_register_file_if #(.WIDTH(8),  .ADDR_W(2)) s();

  src_register_file #(.WIDTH(32), .DEPTH(16), .ADDR_W(4)) u_dut (
    .clock(clock), .clear(clear), .bus(b));
  src_register_file #(.WIDTH(8), .DEPTH(4), .ADDR_W(2)) u_small (
    .clock(clock), .clear(clear), .bus(s));

  int checks = 0;
  int failures = 0;
  logic [31:0] exp_q[$];
  string       tag_q[$];

  task automatic expect_val(input string tag, input logic [31:0] v);
    exp_q.push_back(v);
    tag_q.push_back(tag);
  endtask

  task automatic check_obs(input logic [31:0] obs);
    logic [31:0] e;
    string t;
    e = exp_q.pop_front();
    t = tag_q.pop_front();
    checks++;
    assert (obs === e) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", t, obs, e);
    end
  endtask

  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    @(negedge clock);
    b.wr_en = 1'b1; b.wr_addr = a; b.wr_data = d;
    @(posedge clock); #1;
    b.wr_en = 1'b0;
  endtask

  task automatic rd(input logic [3:0] a, input logic [3:0] bb);
    b.rd_addr_a = a; b.rd_addr_b = bb; #1;
  endtask

  initial begin
    b.wr_en = 0; b.wr_addr = 0; b.wr_data = 0; b.rd_addr_a = 0; b.rd_addr_b = 0;
    b.ba_out = 0; b.rsv_en = 0; b.rsv_addr = 0;
    s.wr_en = 0; s.wr_addr = 0; s.wr_data = 0; s.rd_addr_a = 0; s.rd_addr_b = 0;
    s.ba_out = 0; s.rsv_en = 0; s.rsv_addr = 0;

    // Reset state, and writes/reserves ignored while clear=0
    @(negedge clock);
    b.wr_en = 1; b.wr_addr = 5; b.wr_data = 32'hFFFF_FFFF; b.rsv_en = 1; b.rsv_addr = 5;
    expect_val("rst_rd_a", 0); expect_val("rst_rd_b", 0);
    expect_val("rst_busy", 0); expect_val("rst_any", 0);
    rd(5, 5);
    check_obs(b.rd_data_a); check_obs(b.rd_data_b);
    check_obs({31'b0, b.busy_a}); check_obs({31'b0, b.any_busy});
    @(posedge clock); #1;
    b.wr_en = 0; b.rsv_en = 0;
    expect_val("rst_wr_ignored", 0); expect_val("rst_rsv_ignored", 0);
    rd(5, 5);
    check_obs(b.rd_data_a); check_obs({31'b0, b.any_busy});
    @(negedge clock); clear = 1;

    // Write then read
    wr(5, 32'hDEAD_BEEF);
    expect_val("r5_a", 32'hDEAD_BEEF); expect_val("r5_b", 32'hDEAD_BEEF);
    rd(5, 5);
    check_obs(b.rd_data_a); check_obs(b.rd_data_b);
    for (int i = 0; i < 16; i++) begin
      if (i != 5) begin
        expect_val($sformatf("zero_r%0d", i), 0);
        rd(5, i[3:0]);
        check_obs(b.rd_data_b);
      end
    end

    // Bypass
    wr(3, 32'h1111_1111);
    @(negedge clock);
    b.wr_en = 1; b.wr_addr = 3; b.wr_data = 32'h2222_2222;
    expect_val("byp_a", 32'h2222_2222); expect_val("byp_b_other", 0);
    rd(3, 4);
    check_obs(b.rd_data_a); check_obs(b.rd_data_b);
    expect_val("byp_b", 32'h2222_2222);
    rd(3, 3);
    check_obs(b.rd_data_b);
    @(posedge clock); #1; b.wr_en = 0;
    expect_val("post_a", 32'h2222_2222); expect_val("post_b", 32'h2222_2222);
    rd(3, 3);
    check_obs(b.rd_data_a); check_obs(b.rd_data_b);

    // Base-address masking
    wr(0, 32'h0000_0040);
    @(negedge clock);
    b.ba_out = 1;
    expect_val("ba_a", 0); expect_val("ba_b", 32'h40);
    rd(0, 0);
    check_obs(b.rd_data_a); check_obs(b.rd_data_b);
    b.ba_out = 0;
    expect_val("noba_a", 32'h40);
    rd(0, 0);
    check_obs(b.rd_data_a);
    b.ba_out = 1; b.wr_en = 1; b.wr_addr = 0; b.wr_data = 32'h77;
    expect_val("ba_byp_a", 0); expect_val("ba_byp_b", 32'h77);
    rd(0, 0);
    check_obs(b.rd_data_a); check_obs(b.rd_data_b);
    @(posedge clock); #1; b.wr_en = 0; b.ba_out = 0;
    expect_val("r0_after", 32'h77);
    rd(0, 0);
    check_obs(b.rd_data_a);

    // Scoreboard
    @(negedge clock);
    b.rsv_en = 1; b.rsv_addr = 7;
    expect_val("busy_pre_edge", 0);
    rd(7, 0);
    check_obs({31'b0, b.busy_a});
    @(posedge clock); #1; b.rsv_en = 0;
    expect_val("busy_a7", 1); expect_val("any_busy", 1); expect_val("busy_b0", 0);
    rd(7, 0);
    check_obs({31'b0, b.busy_a}); check_obs({31'b0, b.any_busy}); check_obs({31'b0, b.busy_b});
    wr(7, 32'hAAAA_AAAA);
    expect_val("busy_cleared", 0); expect_val("any_cleared", 0);
    rd(7, 0);
    check_obs({31'b0, b.busy_a}); check_obs({31'b0, b.any_busy});
    @(negedge clock);
    b.rsv_en = 1; b.rsv_addr = 7; b.wr_en = 1; b.wr_addr = 7; b.wr_data = 32'hBBBB_BBBB;
    @(posedge clock); #1; b.rsv_en = 0; b.wr_en = 0;
    expect_val("same_busy", 1); expect_val("same_data", 32'hBBBB_BBBB);
    rd(7, 0);
    check_obs({31'b0, b.busy_a}); check_obs(b.rd_data_a);
    @(negedge clock);
    b.rsv_en = 1; b.rsv_addr = 2; b.wr_en = 1; b.wr_addr = 7; b.wr_data = 32'hCCCC_CCCC;
    @(posedge clock); #1; b.rsv_en = 0; b.wr_en = 0;
    expect_val("diff_busy2", 1); expect_val("diff_busy7", 0); expect_val("diff_data7", 32'hCCCC_CCCC);
    rd(2, 7);
    check_obs({31'b0, b.busy_a}); check_obs({31'b0, b.busy_b}); check_obs(b.rd_data_b);
    wr(10, 32'h1010_1010);
    expect_val("nonpend_busy", 0);
    rd(2, 10);
    check_obs({31'b0, b.busy_b});

    // Async reset mid-operation (R2 still pending)
    wr(9, 32'h1234_5678);
    expect_val("r9_pre", 32'h1234_5678); expect_val("any_pre", 1);
    rd(9, 9);
    check_obs(b.rd_data_a); check_obs({31'b0, b.any_busy});
    #1 clear = 0;
    expect_val("r9_async", 0); expect_val("any_async", 0);
    #1;
    check_obs(b.rd_data_a); check_obs({31'b0, b.any_busy});
    @(negedge clock);
    b.wr_en = 1; b.wr_addr = 9; b.wr_data = 32'hFFFF_0000; b.rsv_en = 1; b.rsv_addr = 9;
    expect_val("rst_byp_gated", 0);
    rd(9, 9);
    check_obs(b.rd_data_b);
    @(posedge clock); #1; b.wr_en = 0; b.rsv_en = 0;
    @(negedge clock); clear = 1;
    expect_val("r9_after_rst", 0); expect_val("any_after_rst", 0);
    rd(9, 9);
    check_obs(b.rd_data_a); check_obs({31'b0, b.any_busy});

    // 8-bit / 4-deep instance
    @(negedge clock);
    s.wr_en = 1; s.wr_addr = 3; s.wr_data = 8'hA5;
    @(posedge clock); #1; s.wr_en = 0;
    s.rd_addr_b = 3;
    expect_val("s_r3", 32'hA5);
    #1 check_obs({24'b0, s.rd_data_b});
    @(negedge clock);
    s.wr_en = 1; s.wr_addr = 0; s.wr_data = 8'h5A;
    @(posedge clock); #1; s.wr_en = 0;
    s.ba_out = 1; s.rd_addr_a = 0; s.rd_addr_b = 0;
    expect_val("s_ba_a", 0); expect_val("s_ba_b", 32'h5A);
    #1 check_obs({24'b0, s.rd_data_a}); check_obs({24'b0, s.rd_data_b});
    s.ba_out = 0;
    @(negedge clock);
    s.rsv_en = 1; s.rsv_addr = 1;
    @(posedge clock); #1; s.rsv_en = 0;
    s.rd_addr_a = 1;
    expect_val("s_busy", 1); expect_val("s_any", 1);
    #1 check_obs({31'b0, s.busy_a}); check_obs({31'b0, s.any_busy});
    @(negedge clock);
    s.wr_en = 1; s.wr_addr = 1; s.wr_data = 8'h3C;
    @(posedge clock); #1; s.wr_en = 0;
    expect_val("s_unbusy", 0); expect_val("s_r1", 32'h3C);
    #1 check_obs({31'b0, s.busy_a}); check_obs({24'b0, s.rd_data_a});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
